seq_subtractor: RTL and testbench
=================================

Name: seq_subtractor

Overview:
Multi-cycle, slice-serial subtractor. It computes D = A - B - Bin over WIDTH/SLICE clock cycles, handling one SLICE-bit slice per cycle and carrying the borrow between cycles in a register. It uses a valid/ready handshake on both the operand side and the result side. It is the subtraction counterpart of the team's adder library, meant for area-constrained datapaths that can trade latency for logic.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; the slice count is N = WIDTH/SLICE.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands are presented.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- Bin  in  1  borrow-in.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result.
- D  out  WIDTH  difference.
- Bout  out  1  borrow-out; 1 when A < B + Bin, unsigned.
- V  out  1  signed overflow of A - B - Bin.
- Z  out  1  D == 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state = IDLE, slice counter = 0, borrow register = 0, operand registers = 0, D = 0, Bout/V/Z = 0, out_valid = 0.
- Reset asserted mid-operation aborts the operation. No out_valid is produced for the aborted operation.
- in_ready is decoded from state: it is 1 only in IDLE. While rst is high, handshakes have no effect.
- FSM, IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch A, B; set borrow reg = Bin; clear counter and D; go to RUN.
- FSM, RUN, one slice per cycle (k = counter):
  - {borrow_next, D[k*SLICE +: SLICE]} = A_k - B_k - borrow, where A_k and B_k are slice k of the latched operands.
  - Borrow reg is updated to borrow_next; counter increments.
  - On the edge that processes k = N-1: register Bout = final borrow, V, and Z; set out_valid = 1; go to DONE.
- FSM, DONE:
  - out_valid = 1. D, Bout, V and Z are held stable.
  - On out_ready: clear out_valid and go to IDLE.
  - in_ready = 0, so new operands are never accepted in the same cycle as the result handshake.
- Latency: out_valid rises N edges after the accepting edge. Minimum initiation interval is N+2 cycles.
- Flag arithmetic:
  - V = (A[W-1] != B[W-1]) & (D[W-1] != A[W-1]), using the latched A and B.
  - Z = ~|D, evaluated on the final D including the last slice.
- D holds partial results during RUN and is meaningful only while out_valid = 1. After the output handshake, D and the flags keep their values until the next accept.
- in_valid during RUN or DONE is ignored. A, B and Bin need only be stable in the accept cycle.
- Wrap-around: 0 - 1 gives all ones with Bout = 1. Bin = 1 with A = B gives all ones with Bout = 1.
- out_ready held high before out_valid rises has no effect until DONE.
- N = 1 (SLICE = WIDTH) is legal: one RUN cycle.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, RUN, DONE.
  - Function/constant for the slice count, N = WIDTH/SLICE.
  - Counter width = clog2 of N, minimum 1.
- Sub-module: sub_slice, a combinational SLICE-bit borrow-lookahead subtractor.
  - Inputs: a, b, bin. Outputs: d, bout.
  - Generate = ~a & b; propagate = ~(a ^ b).
  - Instantiated once in seq_subtractor; the slice is selected by the counter.

Test Plan:
1. WIDTH=32, SLICE=4: A=0x00000005, B=0x00000003, Bin=0 -> D=0x00000002, Bout=0, V=0, Z=0; out_valid exactly 8 edges after accept.
2. A=0x00000000, B=0x00000001, Bin=0 -> D=0xFFFFFFFF, Bout=1, V=0, Z=0 (borrow ripples through all 8 slices). Then A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, Bout=0, V=1.
3. A=0x12345678, B=0x12345677, Bin=1 -> D=0x00000000, Z=1, Bout=0, V=0. Then A=B=0xABCD0000, Bin=1 -> D=0xFFFFFFFF, Bout=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, D and flags stay constant; in_ready=0; in_valid pulses are ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
5. Assert rst asynchronously (between edges) after the third RUN cycle -> out_valid=0, D=0 immediately; after release in_ready=1 and the next operation (0x10 - 0x01) gives D=0x0000000F with correct latency.
6. WIDTH=16, SLICE=8: A=0x1234, B=0x4321, Bin=0 -> D=0xCF13, Bout=1, V=0, latency 2 edges.

Source files
------------

// File: rtl/seq_subtractor_pkg.sv
// seq_subtractor_pkg: shared FSM encoding and sizing helpers for the slice-serial subtractor
package seq_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int slice_count(input int width, input int slice);
    return width / slice;
  endfunction
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_subtractor_sub_slice.sv
// sub_slice: combinational SLICE-bit borrow-lookahead subtractor
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  logic [SLICE-1:0] g, p;
  logic [SLICE:0] c;
  assign g = ~a & b;
  assign p = ~(a ^ b);
  always_comb begin
    c = '0;
    c[0] = bin;
    for (int i = 0; i < SLICE; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign d = a ^ b ^ c[SLICE-1:0];
  assign bout = c[SLICE];
endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: computes D = A - B - Bin one SLICE per cycle with valid/ready handshakes
module seq_subtractor
  import seq_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);
  localparam int N = slice_count(WIDTH, SLICE);
  localparam int CW = cnt_width(N);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic borrow, s_bout, last;
  logic [WIDTH-1:0] a_r, b_r, d_upd;
  logic [SLICE-1:0] s_d;
  sub_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_r[cnt*SLICE +: SLICE]),
    .b   (b_r[cnt*SLICE +: SLICE]),
    .bin (borrow),
    .d   (s_d),
    .bout(s_bout)
  );
  assign last = cnt == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    d_upd = D;
    d_upd[cnt*SLICE +: SLICE] = s_d;
    state_n = (state == IDLE && in_valid) ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Flags are registered from d_upd so the last slice is included in Z and V.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      borrow <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      D <= '0;
      Bout <= 1'b0;
      V <= 1'b0;
      Z <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= A;
      b_r <= B;
      borrow <= Bin;
      cnt <= '0;
      D <= '0;
    end else if (state == RUN) begin
      D <= d_upd;
      borrow <= s_bout;
      cnt <= cnt + 1'b1;
      if (last) begin
        Bout <= s_bout;
        V <= (a_r[WIDTH-1] != b_r[WIDTH-1]) & (d_upd[WIDTH-1] != a_r[WIDTH-1]);
        Z <= ~|d_upd;
      end
    end
  end
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed vector table plus corner sequences for two configurations
module tb_seq_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, v, z;
  logic [31:0] d;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0, d2;
  logic in_ready2, out_valid2, bout2, v2, z2;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .Bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .D(d), .Bout(bout), .V(v), .Z(z)
  );
  seq_subtractor #(.WIDTH(16), .SLICE(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .A(a2), .B(b2), .Bin(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .D(d2), .Bout(bout2), .V(v2), .Z(z2)
  );

  typedef struct {
    logic [31:0] a, b;
    logic bin;
    logic [31:0] d;
    logic bout, v, z;
    logic early;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic accept(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin, input logic early);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = '1; b = '1; bin = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat);
    int edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, exp_lat);
  endtask

  task automatic run_vec(input vec_t t);
    accept(t.a, t.b, t.bin, t.early);
    wait_result(8);
    chk("D", d, t.d);
    chk("Bout", {31'd0, bout}, {31'd0, t.bout});
    chk("V", {31'd0, v}, {31'd0, t.v});
    chk("Z", {31'd0, z}, {31'd0, t.z});
    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("D_held_after_hs", d, t.d);
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] d_hold;
    int e2;
    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'hABCD0000, 32'hABCD0000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDD8A7988, 1'b0, 1'b0, 1'b0, 1'b0};
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_D", d, 32'd0);
    chk("rst_flags", {29'd0, bout, v, z}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // Backpressure: result must hold while out_ready is low and new operands are ignored.
    accept(32'h00000005, 32'h00000003, 1'b0, 1'b0);
    wait_result(8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 32'h55555555 + i; b = 32'h1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_D", d, 32'h00000002);
      chk("bp_flags", {29'd0, bout, v, z}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    // Asynchronous reset in the middle of a run.
    accept(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_D", d, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    accept(32'h00000010, 32'h00000001, 1'b0, 1'b0);
    wait_result(8);
    chk("post_abort_D", d, 32'h0000000F);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // 16-bit, 8-bit-slice configuration.
    chk("w16_in_ready", {31'd0, in_ready2}, 32'd1);
    a2 = 16'h1234; b2 = 16'h4321; in_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    e2 = 0;
    while (!out_valid2 && e2 < 40) begin
      @(posedge clk);
      @(negedge clk);
      e2++;
    end
    chk("w16_latency", e2, 2);
    chk("w16_D", {16'd0, d2}, 32'h0000CF13);
    chk("w16_flags", {29'd0, bout2, v2, z2}, 32'b100);
    d_hold = {16'd0, d2};
    out_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("w16_in_ready_after", {31'd0, in_ready2}, 32'd1);
    chk("w16_D_held", {16'd0, d2}, d_hold);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
